// File: rtl/fan_cmd_parser.sv
// fan_cmd_parser: byte-level command parser behind an SPI slave, driving four
// fan PWM channels. Registers: duty 0-3, control (channel enables), version ID.
//
// state | meaning
// IDLE  | waiting for a command byte
// DATA  | write command seen, next byte is the data for the latched address
// RESP  | read response loaded on oTx, next byte is a dummy that ends the read
// ERR   | malformed command, rx bytes ignored until chip select goes high
module fan_cmd_parser #(
    parameter int         PRESCALE = 4,
    parameter logic [7:0] VERSION  = 8'hA5
) (
    input  logic        sysclk,
    input  logic        iReset,
    input  logic        iRxReady,
    input  logic [7:0]  iRx,
    input  logic        iSPICS,
    output logic        oTxReady,
    output logic [7:0]  oTx,
    output logic [3:0]  oPwm,
    output logic        oErr,
    output logic [15:0] probe
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

    state_t      state, nextState;
    logic        rxSync1, rxSync2, rxSync3;
    logic        csSync1, csSync2;
    logic        rxEvent;
    logic [7:0]  rxCount;
    logic [2:0]  addrReg;
    logic [7:0]  duty [4];
    logic [3:0]  ctrl;
    logic [7:0]  rdData;
    logic [7:0]  prescaler;
    logic [7:0]  pwmCnt;

    logic        addrLoad, regWr, txLoad, txClr, errPulse;

    assign rxEvent = rxSync2 & ~rxSync3;
    assign probe   = {6'b0, state, rxCount};

    // Synchronize the asynchronous SPI handshake and chip select; CS idles high.
    always_ff @(posedge sysclk or posedge iReset) begin
        if (iReset) begin
            rxSync1 <= 1'b0;
            rxSync2 <= 1'b0;
            rxSync3 <= 1'b0;
            csSync1 <= 1'b1;
            csSync2 <= 1'b1;
        end else begin
            rxSync1 <= iRxReady;
            rxSync2 <= rxSync1;
            rxSync3 <= rxSync2;
            csSync1 <= iSPICS;
            csSync2 <= csSync1;
        end
    end

    // Count every received byte, including ones discarded by the FSM.
    always_ff @(posedge sysclk or posedge iReset) begin
        if (iReset) rxCount <= 8'd0;
        else if (rxEvent) rxCount <= rxCount + 8'd1;
    end

    // Read mux addressed directly by the incoming command byte.
    always_comb begin
        rdData = 8'h00;
        case (iRx[2:0])
            3'd0, 3'd1, 3'd2, 3'd3: rdData = duty[iRx[1:0]];
            3'd4:                   rdData = {4'b0, ctrl};
            3'd5:                   rdData = VERSION;
            default:                rdData = 8'h00;
        endcase
    end

    // FSM state register.
    always_ff @(posedge sysclk or posedge iReset) begin
        if (iReset) state <= IDLE;
        else        state <= nextState;
    end

    // FSM next state and action strobes; CS high overrides any rx event.
    always_comb begin
        nextState = state;
        addrLoad  = 1'b0;
        regWr     = 1'b0;
        txLoad    = 1'b0;
        txClr     = 1'b0;
        errPulse  = 1'b0;
        if (csSync2) begin
            nextState = IDLE;
            txClr     = 1'b1;
        end else if (rxEvent) begin
            case (state)
                IDLE: begin
                    if (iRx[6:3] != 4'd0) begin
                        nextState = ERR;
                        errPulse  = 1'b1;
                    end else if (iRx[7]) begin
                        nextState = DATA;
                        addrLoad  = 1'b1;
                    end else begin
                        nextState = RESP;
                        txLoad    = 1'b1;
                    end
                end
                DATA: begin
                    nextState = IDLE;
                    regWr     = 1'b1;
                end
                RESP: begin
                    nextState = IDLE;
                    txClr     = 1'b1;
                end
                default: nextState = ERR;
            endcase
        end
    end

    // Registered FSM outputs: address latch, response byte, error pulse.
    always_ff @(posedge sysclk or posedge iReset) begin
        if (iReset) begin
            addrReg  <= 3'd0;
            oTx      <= 8'h00;
            oTxReady <= 1'b0;
            oErr     <= 1'b0;
        end else begin
            oErr <= errPulse;
            if (addrLoad) addrReg <= iRx[2:0];
            if (txLoad) begin
                oTx      <= rdData;
                oTxReady <= 1'b1;
            end else if (txClr) begin
                oTxReady <= 1'b0;
            end
        end
    end

    // Register file writes; addresses 5-7 are read-only and drop writes.
    always_ff @(posedge sysclk or posedge iReset) begin
        if (iReset) begin
            for (int i = 0; i < 4; i++) duty[i] <= 8'h00;
            ctrl <= 4'hF;
        end else if (regWr) begin
            case (addrReg)
                3'd0, 3'd1, 3'd2, 3'd3: duty[addrReg[1:0]] <= iRx;
                3'd4:                   ctrl <= iRx[3:0];
                default: ;
            endcase
        end
    end

    // Prescaler and 255-tick PWM period counter (0..254).
    always_ff @(posedge sysclk or posedge iReset) begin
        if (iReset) begin
            prescaler <= 8'd0;
            pwmCnt    <= 8'd0;
        end else if (prescaler == PRE_LAST) begin
            prescaler <= 8'd0;
            pwmCnt    <= (pwmCnt == 8'd254) ? 8'd0 : pwmCnt + 8'd1;
        end else begin
            prescaler <= prescaler + 8'd1;
        end
    end

    // Registered PWM compare; duty 255 never reaches since pwmCnt tops at 254.
    always_ff @(posedge sysclk or posedge iReset) begin
        if (iReset) begin
            oPwm <= 4'h0;
        end else begin
            for (int n = 0; n < 4; n++) oPwm[n] <= ctrl[n] & (pwmCnt < duty[n]);
        end
    end

endmodule

// File: tb/tb_fan_cmd_parser.sv
// Directed bench for fan_cmd_parser with a response scoreboard and PWM duty
// measurement over one full period (PRESCALE=1, so 255 cycles).
module tb_fan_cmd_parser;

    logic        sysclk = 1'b0;
    logic        iReset = 1'b1;
    logic        iRxReady = 1'b0;
    logic [7:0]  iRx = 8'h00;
    logic        iSPICS = 1'b1;
    logic        oTxReady;
    logic [7:0]  oTx;
    logic [3:0]  oPwm;
    logic        oErr;
    logic [15:0] probe;

    int checks = 0;
    int failures = 0;
    int errHigh = 0;
    int popped = 0;
    int pushed = 0;
    logic [7:0] expRx = 8'd0;
    logic [7:0] sbQ [$];
    logic prevTxRdy = 1'b0;

    fan_cmd_parser #(.PRESCALE(1), .VERSION(8'hA5)) dut (
        .sysclk(sysclk), .iReset(iReset), .iRxReady(iRxReady), .iRx(iRx),
        .iSPICS(iSPICS), .oTxReady(oTxReady), .oTx(oTx), .oPwm(oPwm),
        .oErr(oErr), .probe(probe)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare each new response against the oldest expected value.
    always @(negedge sysclk) begin
        if (oErr) errHigh++;
        if (oTxReady && !prevTxRdy && !iReset) begin
            if (sbQ.size() == 0) begin
                check("sb_unexpected_resp", 16'(oTx), 16'hFFFF);
            end else begin
                check("sb_resp", 16'(oTx), 16'(sbQ.pop_front()));
                popped++;
            end
        end
        prevTxRdy = oTxReady;
    end

    task automatic waitCyc(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(posedge sysclk); #1;
        iRx = b;
        iRxReady = 1'b1;
        expRx = expRx + 8'd1;
        waitCyc(4);
        iRxReady = 1'b0;
        waitCyc(4);
    endtask

    task automatic setCs(input logic v);
        @(posedge sysclk); #1;
        iSPICS = v;
        waitCyc(4);
    endtask

    task automatic readReg(input logic [2:0] a, input logic [7:0] exp);
        sbQ.push_back(exp);
        pushed++;
        sendByte({5'b0, a});
        sendByte(8'h00);
    endtask

    task automatic measurePwm(output int cnt [4]);
        for (int n = 0; n < 4; n++) cnt[n] = 0;
        for (int c = 0; c < 255; c++) begin
            @(negedge sysclk);
            for (int n = 0; n < 4; n++) if (oPwm[n]) cnt[n]++;
        end
        #1;
    endtask

    initial begin : stim
        int cnt [4];
        int errBefore;
        logic [15:0] lastTx;

        // Reset values
        waitCyc(3);
        check("rst_oTx", 16'(oTx), 16'h0000);
        check("rst_oTxReady", 16'(oTxReady), 16'h0000);
        check("rst_oPwm", 16'(oPwm), 16'h0000);
        check("rst_oErr", 16'(oErr), 16'h0000);
        check("rst_probe", probe, 16'h0000);
        iReset = 1'b0;
        waitCyc(2);
        setCs(1'b0);

        // Version read: ready after command, cleared after dummy, oTx holds
        sbQ.push_back(8'hA5);
        pushed++;
        sendByte(8'h05);
        check("ver_txready_hi", 16'(oTxReady), 16'h0001);
        sendByte(8'h00);
        check("ver_txready_lo", 16'(oTxReady), 16'h0000);
        check("ver_tx_hold", 16'(oTx), 16'h00A5);
        check("ver_state_idle", 16'(probe[9:8]), 16'h0000);

        // Duty write on channel 1 and 128/255 PWM high time
        sendByte(8'h81);
        sendByte(8'h80);
        readReg(3'd1, 8'h80);
        measurePwm(cnt);
        check("pwm1_128", 16'(cnt[1]), 16'd128);
        check("pwm0_zero", 16'(cnt[0]), 16'd0);

        // Malformed command: one-cycle error, ERR ignores bytes until CS high
        errBefore = errHigh;
        sendByte(8'h48);
        check("err_pulse_one", 16'(errHigh - errBefore), 16'd1);
        check("err_state", 16'(probe[9:8]), 16'h0003);
        sendByte(8'h82);
        check("err_stays", 16'(probe[9:8]), 16'h0003);
        setCs(1'b1);
        check("cs_idle", 16'(probe[9:8]), 16'h0000);
        setCs(1'b0);
        readReg(3'd2, 8'h00);
        sendByte(8'h82);
        sendByte(8'hFF);
        measurePwm(cnt);
        check("pwm2_const1", 16'(cnt[2]), 16'd255);

        // Abandoned write on channel 3 keeps the old duty
        sendByte(8'h83);
        sendByte(8'h40);
        sendByte(8'h83);
        check("data_state", 16'(probe[9:8]), 16'h0001);
        setCs(1'b1);
        check("abandon_idle", 16'(probe[9:8]), 16'h0000);
        setCs(1'b0);
        readReg(3'd3, 8'h40);

        // Rx event while CS high: counted, but no write and no error
        setCs(1'b1);
        errBefore = errHigh;
        sendByte(8'h48);
        sendByte(8'h83);
        sendByte(8'h11);
        check("cshi_no_err", 16'(errHigh - errBefore), 16'd0);
        check("cshi_rxcount", 16'(probe[7:0]), 16'(expRx));
        setCs(1'b0);
        readReg(3'd3, 8'h40);

        // Enable only channel 0; duty 0 gives constant low, then 16/255
        sendByte(8'h84);
        sendByte(8'h01);
        readReg(3'd4, 8'h01);
        measurePwm(cnt);
        check("en_pwm0_zero", 16'(cnt[0]), 16'd0);
        check("en_pwm1_off", 16'(cnt[1]), 16'd0);
        check("en_pwm2_off", 16'(cnt[2]), 16'd0);
        sendByte(8'h80);
        sendByte(8'h10);
        measurePwm(cnt);
        check("pwm0_16", 16'(cnt[0]), 16'd16);
        check("pwm3_off", 16'(cnt[3]), 16'd0);

        // Read-only and unmapped addresses
        sendByte(8'h85);
        sendByte(8'h77);
        readReg(3'd5, 8'hA5);
        readReg(3'd6, 8'h00);
        readReg(3'd7, 8'h00);
        check("rxcount", 16'(probe[7:0]), 16'(expRx));

        // Reset in DATA: everything back to reset values, next byte is a command
        sendByte(8'h81);
        check("pre_rst_data", 16'(probe[9:8]), 16'h0001);
        lastTx = 16'(oTx);
        check("pre_rst_tx", lastTx, 16'h0000);
        @(posedge sysclk); #1;
        iReset = 1'b1;
        waitCyc(3);
        check("rst2_probe", probe, 16'h0000);
        check("rst2_oPwm", 16'(oPwm), 16'h0000);
        check("rst2_oTxReady", 16'(oTxReady), 16'h0000);
        check("rst2_oErr", 16'(oErr), 16'h0000);
        iReset = 1'b0;
        expRx = 8'd0;
        prevTxRdy = 1'b0;
        waitCyc(4);
        readReg(3'd4, 8'h0F);
        readReg(3'd1, 8'h00);
        check("post_rst_rxcount", 16'(probe[7:0]), 16'(expRx));

        waitCyc(4);
        check("sb_drained", 16'(sbQ.size()), 16'd0);
        check("sb_count", 16'(popped), 16'(pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fan_cmd_parser.md
FAN_CMD_PARSER -- requirements
Module: fan_cmd_parser

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 4, meaning sysclk cycles per PWM counter tick (legal range 1..255).
REQ-002 The block SHALL have parameter VERSION, default 8'hA5, meaning the read-only ID value returned at address 5.
REQ-003 The block SHALL have port sysclk  in  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port iReset  in  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port iRxReady  in  1  byte-valid level from the SPI slave, asynchronous to sysclk.
REQ-006 The block SHALL have port iRx  in  8  received byte, stable while iRxReady is high.
REQ-007 The block SHALL have port iSPICS  in  1  SPI chip select, active low, asynchronous to sysclk.
REQ-008 The block SHALL have port oTxReady  out  1  response byte valid, to the SPI slave txReady input.
REQ-009 The block SHALL have port oTx  out  8  response byte, to the SPI slave tx input.
REQ-010 The block SHALL have port oPwm  out  4  fan PWM outputs, one per channel.
REQ-011 The block SHALL have port oErr  out  1  one-cycle pulse on a malformed command byte.
REQ-012 The block SHALL have port probe  out  16  debug bus: {6'b0, state[1:0], rxCount[7:0]}.

Function
REQ-013 iRxReady and iSPICS SHALL each pass through a two-flop synchronizer; rx event = rising edge of the synchronized iRxReady (sync2 & !sync3).
REQ-014 iRx SHALL be sampled on the cycle the rx event is high; rxCount SHALL increment (mod 256) on every rx event.
REQ-015 Command byte: bit7 = 1 write, 0 read; bits 6:3 must be 0; bits 2:0 = register address.
REQ-016 Register map: 0-3 duty for channel 0-3 (R/W); 4 control, bits 3:0 = channel enables (R/W, bits 7:4 read 0); 5 VERSION (RO); 6-7 read 8'h00; writes to 5-7 SHALL be ignored.
REQ-017 States: IDLE, DATA, RESP, ERR, encoded 0, 1, 2, 3.
REQ-018 IDLE + rx event, valid write command -> DATA, address latched.
REQ-019 IDLE + rx event, valid read command -> RESP; in the same edge oTx <= register value and oTxReady <= 1.
REQ-020 IDLE + rx event, bits 6:3 nonzero -> ERR; oErr high for exactly one cycle.
REQ-021 DATA + rx event -> register at latched address <= iRx on that edge; next state IDLE.
REQ-022 RESP + rx event -> byte discarded, oTxReady <= 0, next state IDLE; oTx holds its value.
REQ-023 ERR SHALL ignore all rx events until synchronized iSPICS is high.
REQ-024 Synchronized iSPICS high in any state -> IDLE and oTxReady <= 0 on the next edge.
REQ-025 If synchronized iSPICS is high and an rx event occurs in the same cycle, the rx event SHALL be discarded with no register write and no oErr; rxCount still increments.
REQ-026 Multiple commands SHALL be accepted back-to-back within one CS-low frame without CS toggling.
REQ-027 PWM: prescaler counts 0..PRESCALE-1; on wrap the 8-bit pwmCnt advances 0..254 then wraps to 0 (period 255 ticks).
REQ-028 oPwm[n] = enable[n] & (pwmCnt < duty[n]), registered; duty 0 -> constant 0; duty 255 -> constant 1 while enabled.
REQ-029 Duty writes SHALL take effect immediately; no period-boundary shadowing.

Reset
REQ-030 While iReset is high: state IDLE; duty 0-3 = 0; control = 8'h0F; oTx = 0; oTxReady = 0; oPwm = 0; oErr = 0; rxCount = 0; prescaler and pwmCnt = 0; synchronizers = 0 for iRxReady and 1 for iSPICS.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction; after release the first rx event is treated as a command byte.

Verification
REQ-032 Frame CS low, bytes 8'h81, 8'h80 -> duty[1] = 8'h80; with PRESCALE=1, oPwm[1] high for 128 of every 255 cycles.
REQ-033 Frame bytes 8'h05, 8'h00 -> oTx = 8'hA5, oTxReady high after the first byte, low after the second; state IDLE.
REQ-034 Byte 8'h48 -> oErr one-cycle pulse; following byte 8'h82 ignored (duty[2] unchanged); after CS high then low, 8'h82, 8'hFF -> duty[2] = 8'hFF, oPwm[2] constant 1.
REQ-035 Write 8'h84, 8'h01 -> only oPwm[0] can toggle; duty 0 on channel 0 -> oPwm[0] constant 0.
REQ-036 Byte 8'h83 then CS high before data byte -> state IDLE, duty[3] unchanged; next frame 8'h03, 8'h00 returns the old duty[3].
REQ-037 iReset pulsed while in DATA -> all outputs at reset values; next byte 8'h04 followed by 8'h00 reads back 8'h0F.
